// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the state-update datapath: widths, round count,
// the FIPS 180-4 initial hash value and the control FSM state type.
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int WORDS  = 8;
  localparam int IDX_W  = 6;

  // H0..H7 with H0 in the most significant word
  localparam logic [WORDS*WORD_W-1:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sha256_digest_add.sv
// Final feed-forward of a compression: eight independent 32-bit modular adds,
// purely combinational so the parent decides when the result is captured.
module sha256_digest_add
  import sha256_pkg::*;
(
  input  logic [WORDS*WORD_W-1:0] h_words,
  input  logic [WORDS*WORD_W-1:0] work,
  output logic [WORDS*WORD_W-1:0] sum
);

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign sum[i*WORD_W +: WORD_W] = h_words[i*WORD_W +: WORD_W] + work[i*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/sha256_state_update.sv
// Working-variable register file and round sequencer for one SHA-256 compression;
// T1/T2 arrive from external stages and may stall indefinitely via t_valid.
module sha256_state_update
  import sha256_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WORDS*WORD_W-1:0] h_in,
  input  logic [WORD_W-1:0]       t1,
  input  logic [WORD_W-1:0]       t2,
  input  logic                    t_valid,
  output logic [WORD_W-1:0]       a_out,
  output logic [WORD_W-1:0]       b_out,
  output logic [WORD_W-1:0]       c_out,
  output logic [WORD_W-1:0]       d_out,
  output logic [WORD_W-1:0]       e_out,
  output logic [WORD_W-1:0]       f_out,
  output logic [WORD_W-1:0]       g_out,
  output logic [WORD_W-1:0]       h_out,
  output logic [IDX_W-1:0]        round_idx,
  output logic                    busy,
  output logic                    done,
  output logic [WORDS*WORD_W-1:0] digest
);

  state_t                  state;
  logic [WORDS*WORD_W-1:0] h_lat;
  logic [WORDS*WORD_W-1:0] sum;

  sha256_digest_add u_digest_add (
    .h_words (h_lat),
    .work    ({a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out}),
    .sum     (sum)
  );

  // busy/done are registered alongside the state so they line up with it exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      h_lat     <= '0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      d_out     <= '0;
      e_out     <= '0;
      f_out     <= '0;
      g_out     <= '0;
      h_out     <= '0;
      round_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digest    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            h_lat     <= h_in;
            {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} <= h_in;
            round_idx <= '0;
            busy      <= 1'b1;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (t_valid) begin
            h_out <= g_out;
            g_out <= f_out;
            f_out <= e_out;
            e_out <= d_out + t1;
            d_out <= c_out;
            c_out <= b_out;
            b_out <= a_out;
            a_out <= t1 + t2;
            // the index parks at 0 once the last round has consumed its operands
            if (round_idx == IDX_W'(ROUNDS - 1)) begin
              round_idx <= '0;
              state     <= ST_FINAL;
            end else begin
              round_idx <= round_idx + 1'b1;
            end
          end
        end
        ST_FINAL: begin
          digest <= sum;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_state_update.sv
// Self-checking bench: a phase-level SHA-256 compression model drives T1/T2 and
// is compared against the DUT every cycle, plus literal digest/latency pins.
module tb_sha256_state_update;

  localparam logic [255:0] FIPS_H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] h_in = '0;
  logic [31:0]  t1 = '0;
  logic [31:0]  t2 = '0;
  logic         t_valid = 1'b0;
  logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
  logic [5:0]   round_idx;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  always #5 clk = ~clk;

  sha256_state_update dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .h_in      (h_in),
    .t1        (t1),
    .t2        (t2),
    .t_valid   (t_valid),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .e_out     (e_out),
    .f_out     (f_out),
    .g_out     (g_out),
    .h_out     (h_out),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .digest    (digest)
  );

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] w_abc [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Model: phase 0 idle, 1 rounds, 2 feed-forward, 3 done pulse
  logic [31:0] m_h [8];
  logic [31:0] m_w [8];
  logic [31:0] m_dig [8];
  int m_phase = 0;
  int m_rnd = 0;

  always @(posedge clk) begin : model
    logic [31:0] na, ne;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_h[i] = '0;
        m_w[i] = '0;
        m_dig[i] = '0;
      end
      m_phase = 0;
      m_rnd = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          for (int i = 0; i < 8; i++) begin
            m_h[i] = h_in[255-32*i -: 32];
            m_w[i] = h_in[255-32*i -: 32];
          end
          m_rnd = 0;
          m_phase = 1;
        end
        1: if (t_valid) begin
          na = t1 + t2;
          ne = m_w[3] + t1;
          for (int i = 7; i > 0; i--) m_w[i] = m_w[i-1];
          m_w[0] = na;
          m_w[4] = ne;
          m_rnd++;
          if (m_rnd == 64) begin
            m_rnd = 0;
            m_phase = 2;
          end
        end
        2: begin
          for (int i = 0; i < 8; i++) m_dig[i] = m_h[i] + m_w[i];
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy", 256'(busy), 256'(m_phase == 1 || m_phase == 2));
      checkOutput("done", 256'(done), 256'(m_phase == 3));
      checkOutput("round_idx", 256'(round_idx), 256'(m_rnd));
      checkOutput("work_vars", {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out},
                  {m_w[0], m_w[1], m_w[2], m_w[3], m_w[4], m_w[5], m_w[6], m_w[7]});
      checkOutput("digest", digest,
                  {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dig[4], m_dig[5], m_dig[6], m_dig[7]});
    end
  end

  // mode: 0 no stalls, 1 stall once on rounds 0/31/63, 2 random stalls, 3 stray start pulses
  task automatic applyStimulus(input logic [255:0] hv, input bit abc, input int mode,
                               input int reset_round, output int done_cyc, output int stalls);
    bit stalled [64];
    int cyc;
    done_cyc = -1;
    stalls = 0;
    for (int i = 0; i < 64; i++) stalled[i] = 1'b0;
    h_in = hv;
    start = 1'b1;
    t_valid = 1'b0;
    cyc = 1;
    @(posedge clk);
    @(negedge clk);
    cyc = 2;
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (done) begin
        done_cyc = cyc;
        if (mode == 3) begin
          start = 1'b1;
          h_in = {8{$urandom}};
        end
        break;
      end
      if (reset_round >= 0 && m_phase == 1 && m_rnd == reset_round) begin
        rst_n = 1'b0;
        t_valid = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        t_valid = 1'b0;
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_round_idx", 256'(round_idx), 256'(0));
        checkOutput("rst_a_out", 256'(a_out), 256'(0));
        for (int j = 0; j < 4; j++) begin
          checkOutput("rst_no_done", 256'(done), 256'(0));
          @(posedge clk);
          @(negedge clk);
        end
        return;
      end
      t_valid = 1'b1;
      if (m_phase == 1) begin
        if (mode == 1 && (m_rnd == 0 || m_rnd == 31 || m_rnd == 63) && !stalled[m_rnd]) begin
          t_valid = 1'b0;
          stalled[m_rnd] = 1'b1;
        end
        if (mode == 2 && $urandom_range(0, 3) == 0) t_valid = 1'b0;
        if (!t_valid) stalls++;
        if (abc) begin
          t1 = m_w[7] + bsig1(m_w[4]) + ((m_w[4] & m_w[5]) ^ (~m_w[4] & m_w[6])) + k_tab[m_rnd] + w_abc[m_rnd];
          t2 = bsig0(m_w[0]) + ((m_w[0] & m_w[1]) ^ (m_w[0] & m_w[2]) ^ (m_w[1] & m_w[2]));
        end else begin
          t1 = $urandom;
          t2 = $urandom;
        end
        start = (mode == 3 && m_rnd == 10);
        if (start) h_in = {8{$urandom}};
      end else begin
        t1 = $urandom;
        t2 = $urandom;
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    t_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (mode == 3) checkOutput("start_in_done_ignored", 256'(busy), 256'(0));
    start = 1'b0;
  endtask

  initial begin
    int dc, st;
    logic [255:0] hv;
    for (int i = 0; i < 16; i++) w_abc[i] = '0;
    w_abc[0] = 32'h61626380;
    w_abc[15] = 32'h00000018;
    for (int i = 16; i < 64; i++)
      w_abc[i] = ssig1(w_abc[i-2]) + w_abc[i-7] + ssig0(w_abc[i-15]) + w_abc[i-16];

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 256'(busy), 256'(0));
    checkOutput("reset_done", 256'(done), 256'(0));
    checkOutput("reset_digest", digest, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] abc block, no stalls");
    applyStimulus(FIPS_H0, 1'b1, 0, -1, dc, st);
    checkOutput("abc_digest", digest, ABC_DIGEST);
    checkOutput("abc_done_cycle", 256'(dc), 256'(67));

    $display("[TB] abc block, stalls on rounds 0/31/63");
    applyStimulus(FIPS_H0, 1'b1, 1, -1, dc, st);
    checkOutput("stall_digest", digest, ABC_DIGEST);
    checkOutput("stall_done_cycle", 256'(dc), 256'(70));

    $display("[TB] modular wrap on first round");
    h_in = {96'h0, 32'h00000001, 128'h0};
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    t1 = 32'hFFFFFFFF;
    t2 = 32'hFFFFFFFF;
    t_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    checkOutput("wrap_a", 256'(a_out), 256'(32'hFFFFFFFE));
    checkOutput("wrap_e", 256'(e_out), 256'(32'h00000000));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset at round 40, then restart");
    applyStimulus(FIPS_H0, 1'b1, 0, 40, dc, st);
    checkOutput("rst_abandon_no_done", 256'(dc), 256'(-1));
    applyStimulus(FIPS_H0, 1'b1, 0, -1, dc, st);
    checkOutput("restart_digest", digest, ABC_DIGEST);
    checkOutput("restart_done_cycle", 256'(dc), 256'(67));

    $display("[TB] stray start pulses during ROUND and DONE");
    applyStimulus(FIPS_H0, 1'b1, 3, -1, dc, st);
    checkOutput("poke_digest", digest, ABC_DIGEST);
    checkOutput("poke_done_cycle", 256'(dc), 256'(67));

    $display("[TB] randomized compressions");
    for (int r = 0; r < 4; r++) begin
      hv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus(hv, 1'b0, 2, -1, dc, st);
      checkOutput("rand_done_cycle", 256'(dc), 256'(67 + st));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
